sr_driver: RTL and testbench
============================

SR_DRIVER -- requirements
Module: sr_driver

Interface
REQ-001 SHALL have parameter PULSE_W, default 2, width in cycles of each s/r drive pulse (legal range 1..15).
REQ-002 SHALL have parameter GUARD_W, default 1, dead-time in cycles with s=r=0 after each pulse (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_op  input  2  command: 00 hold, 01 set, 10 reset, 11 illegal.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port s  output  1  registered set drive to the downstream SR latch.
REQ-009 SHALL have port r  output  1  registered reset drive to the downstream SR latch.
REQ-010 SHALL have port q_fb  input  1  latch Q fed back for checking.
REQ-011 SHALL have port q_exp  output  1  expected latch state.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-013 SHALL have port err_illegal  output  1  one-cycle pulse on an accepted op 11.
REQ-014 SHALL have port err_mismatch  output  1  sticky: q_fb disagreed with q_exp at check.

Function
REQ-015 SHALL implement FSM states IDLE, PULSE, GUARD and CHECK.
REQ-016 SHALL drive cmd_ready = (state == IDLE), combinationally from state.
REQ-017 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_op is sampled only on that edge.
REQ-018 On accepted op 01: SHALL go IDLE->PULSE, s=1 for exactly PULSE_W cycles, and set q_exp=1 on the accept edge.
REQ-019 On accepted op 10: SHALL go IDLE->PULSE, r=1 for exactly PULSE_W cycles, and set q_exp=0 on the accept edge.
REQ-020 On accepted op 00: SHALL stay IDLE with no pulse and no flag change.
REQ-021 On accepted op 11: SHALL stay IDLE, pulse err_illegal for one cycle, and leave s, r and q_exp unchanged.
REQ-022 PULSE SHALL go to GUARD after PULSE_W cycles; GUARD SHALL hold s=r=0 for GUARD_W cycles, then go to CHECK.
REQ-023 CHECK SHALL last one cycle: if q_fb != q_exp, set err_mismatch; then go to IDLE.
REQ-024 err_mismatch SHALL clear on the next accepted set or reset command and on reset only.
REQ-025 s and r SHALL never be 1 in the same cycle, including across back-to-back commands.
REQ-026 A redundant command (set while q_exp=1) SHALL still produce a full pulse, guard and check sequence.
REQ-027 Latency with default parameters: accept at edge k; s or r high during cycles k+1..k+2; guard at k+3; check at k+4; cmd_ready=1 from k+5.
REQ-028 The pulse/guard counter SHALL be 4 bits, SHALL load on state entry, and SHALL count down to 1; it SHALL never wrap.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, s=0, r=0, q_exp=0, err_illegal=0, err_mismatch=0, counter=0, and busy=0.
REQ-030 No command SHALL be accepted while rst_n is low.
REQ-031 A reset during PULSE SHALL drop s/r in the same cycle; no check SHALL follow.

Structure
REQ-032 Package sr_pkg SHALL hold the cmd_op encoding enum, the FSM state enum and the counter width constant (4).
REQ-033 The pulse/guard timing SHALL be one sub-module, sr_dwell_counter, with ports load, load_val, done.
REQ-034 s, r, q_exp and both error flags SHALL be flops; no output SHALL be combinational except cmd_ready and busy.

Verification
REQ-035 The bench SHALL cover: after reset, op 01 accepted -> s=1 for 2 cycles, r=0, q_exp=1, with q_fb model=1 -> err_mismatch=0.
REQ-036 The bench SHALL cover: set immediately followed by reset with cmd_valid held -> second accept 5 cycles after first, at least 1 cycle with s=r=0 between pulses, and s&r never both 1.
REQ-037 The bench SHALL cover: op 10 with q_fb stuck at 1 -> err_mismatch=1 at check+1, held through op 00, cleared by the next op 01 accept.
REQ-038 The bench SHALL cover: op 11 -> err_illegal high exactly 1 cycle, s=r=0, q_exp unchanged, cmd_ready stays 1.
REQ-039 The bench SHALL cover: rst_n pulled low on the second cycle of an s pulse -> s=0 asynchronously, q_exp=0, and cmd_ready=1 on the first edge after release.
REQ-040 The bench SHALL cover: PULSE_W=1, GUARD_W=3 -> s pulse width 1, guard 3, and cmd_ready back 6 cycles after accept.

Source files
------------

// File: rtl/sr_pkg.sv
// +----------------------------------------------------------------------+
// | sr_pkg                                                               |
// | Shared types and constants for the SR latch pulse driver.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package sr_pkg;

  localparam int c_CNT_W = 4;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_SET     = 2'b01,
    OP_RESET   = 2'b10,
    OP_ILLEGAL = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sr_dwell_counter.sv
// +----------------------------------------------------------------------+
// | sr_dwell_counter                                                     |
// | Loadable down-counter timing the pulse and guard phases.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sr_dwell_counter
  import sr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [c_CNT_W-1:0] load_val,
  output logic               done
);

  localparam logic [c_CNT_W-1:0] c_ONE = 1;

  logic [c_CNT_W-1:0] r_cnt;

  // Parks at 1 once a phase has elapsed so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt > c_ONE) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

  assign done = (r_cnt == c_ONE);

endmodule

`default_nettype wire

// File: rtl/sr_driver.sv
// +----------------------------------------------------------------------+
// | sr_driver                                                            |
// | Drives set/reset pulses into an SR latch with guard time and check.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sr_driver
  import sr_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GUARD_W = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  output logic       q_exp,
  output logic       busy,
  output logic       err_illegal,
  output logic       err_mismatch
);

  localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_W);
  localparam logic [c_CNT_W-1:0] c_GUARD_LD = c_CNT_W'(GUARD_W);

  state_e             r_state;
  logic               r_s;
  logic               r_r;
  logic               r_q_exp;
  logic               r_err_illegal;
  logic               r_err_mismatch;
  cmd_op_e            w_op;
  logic               w_accept;
  logic               w_start;
  logic               w_load;
  logic [c_CNT_W-1:0] w_load_val;
  logic               w_dwell_done;

  assign w_op     = cmd_op_e'(cmd_op);
  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_start  = w_accept && ((w_op == OP_SET) || (w_op == OP_RESET));

  // The counter is reloaded on entry to PULSE and again on entry to GUARD.
  assign w_load     = w_start || ((r_state == ST_PULSE) && w_dwell_done);
  assign w_load_val = (r_state == ST_PULSE) ? c_GUARD_LD : c_PULSE_LD;

  sr_dwell_counter u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .done     (w_dwell_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_s            <= 1'b0;
      r_r            <= 1'b0;
      r_q_exp        <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_mismatch <= 1'b0;
    end else begin
      r_err_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_SET: begin
                r_state        <= ST_PULSE;
                r_s            <= 1'b1;
                r_q_exp        <= 1'b1;
                r_err_mismatch <= 1'b0;
              end
              OP_RESET: begin
                r_state        <= ST_PULSE;
                r_r            <= 1'b1;
                r_q_exp        <= 1'b0;
                r_err_mismatch <= 1'b0;
              end
              OP_ILLEGAL: r_err_illegal <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_PULSE: begin
          if (w_dwell_done) begin
            r_state <= ST_GUARD;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end
        end
        ST_GUARD: begin
          if (w_dwell_done) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (q_fb != r_q_exp) begin
            r_err_mismatch <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign s            = r_s;
  assign r            = r_r;
  assign q_exp        = r_q_exp;
  assign err_illegal  = r_err_illegal;
  assign err_mismatch = r_err_mismatch;

endmodule

`default_nettype wire

// File: tb/tb_sr_driver.sv
// +----------------------------------------------------------------------+
// | tb_sr_driver                                                         |
// | Self-checking bench for sr_driver against a cycle-offset model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_sr_driver;

  localparam int P = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       q_fb = 1'b0;
  logic       cmd_ready, s, r, q_exp, busy, err_illegal, err_mismatch;

  logic       b_cmd_valid = 1'b0;
  logic [1:0] b_cmd_op = 2'b00;
  logic       b_cmd_ready, b_s, b_r, b_q_exp, b_busy, b_err_illegal, b_err_mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_j counts cycles since the accept edge (0 means idle).
  int         m_j = 0;
  logic [1:0] m_op = 2'b00;
  logic       m_qexp = 1'b0;
  logic       m_err_ill = 1'b0;
  logic       m_err_mis = 1'b0;
  logic       q_latch = 1'b0;
  bit         stuck_en = 1'b0;
  logic       stuck_val = 1'b0;
  logic [6:0] got;

  always #5 clk = ~clk;

  sr_driver #(.PULSE_W(P), .GUARD_W(G)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .s(s), .r(r), .q_fb(q_fb), .q_exp(q_exp),
    .busy(busy), .err_illegal(err_illegal), .err_mismatch(err_mismatch)
  );

  sr_driver #(.PULSE_W(1), .GUARD_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_op(b_cmd_op),
    .cmd_ready(b_cmd_ready), .s(b_s), .r(b_r), .q_fb(1'b1), .q_exp(b_q_exp),
    .busy(b_busy), .err_illegal(b_err_illegal), .err_mismatch(b_err_mismatch)
  );

  // {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch}
  function automatic logic [6:0] exp_vec();
    logic in_pulse;
    in_pulse = (m_j >= 1) && (m_j <= P);
    return {in_pulse && (m_op == 2'b01), in_pulse && (m_op == 2'b10), m_qexp,
            m_j != 0, m_j == 0, m_err_ill, m_err_mis};
  endfunction

  task automatic model_reset();
    m_j = 0; m_qexp = 1'b0; m_err_ill = 1'b0; m_err_mis = 1'b0;
  endtask

  // One clock edge plus the model update; leaves time at posedge+1.
  task automatic cycle();
    bit acc, chk, bad;
    acc = rst_n && cmd_valid && (m_j == 0);
    chk = (m_j == P + G + 1);
    bad = (q_fb !== m_qexp);
    @(posedge clk); #1;
    m_err_ill = acc && (cmd_op == 2'b11);
    if (chk) begin
      if (bad) m_err_mis = 1'b1;
      m_j = 0;
    end else if (m_j != 0) begin
      m_j++;
    end
    if (acc && (cmd_op == 2'b01 || cmd_op == 2'b10)) begin
      m_j = 1; m_op = cmd_op; m_qexp = (cmd_op == 2'b01); m_err_mis = 1'b0;
    end
    if (s) q_latch = 1'b1;
    else if (r) q_latch = 1'b0;
    q_fb = stuck_en ? stuck_val : q_latch;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
      n_checks++;
      if (got !== 7'b0000100) begin
        n_fail++; $display("FAIL reset_state: got %b exp %b", got, 7'b0000100);
      end
    end
    cmd_valid = 1'b0; q_latch = 1'b0; q_fb = 1'b0;
    rst_n = 1'b1; model_reset();
  endtask

  task automatic test_set();
    int s_cnt = 0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cycle(); cmd_valid = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++; $display("FAIL set_seq j=%0d: got %b exp %b", j, got, exp_vec());
      end
      if (s) s_cnt++;
      if (j < 6) cycle();
    end
    n_checks++;
    if (s_cnt != 2 || q_exp !== 1'b1 || err_mismatch !== 1'b0) begin
      n_fail++; $display("FAIL set_summary: s_cycles=%0d q_exp=%b err_mis=%b exp 2 1 0",
                         s_cnt, q_exp, err_mismatch);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1, gap = 0, overlap = 0;
    bit seen_s = 0, seen_r = 0;
    cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int t = 0; t < 14; t++) begin
      if (cmd_valid && m_j == 0) begin
        if (first < 0) first = t; else second = t;
      end
      cycle();
      if (first >= 0) cmd_op = 2'b10;
      if (second >= 0) cmd_valid = 1'b0;
      got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_seq t=%0d: got %b exp %b", t, got, exp_vec());
      end
      if (s && r) overlap++;
      if (seen_s && !seen_r && !s && !r) gap++;
      if (s) seen_s = 1;
      if (r) seen_r = 1;
    end
    n_checks++;
    if (second - first != 5) begin
      n_fail++; $display("FAIL b2b_accept_spacing: got %0d exp 5", second - first);
    end
    n_checks++;
    if (gap < 1 || overlap != 0 || !seen_r) begin
      n_fail++; $display("FAIL b2b_gap: gap=%0d overlap=%0d seen_r=%0d exp gap>=1 overlap=0 seen_r=1",
                         gap, overlap, seen_r);
    end
  endtask

  task automatic test_mismatch();
    stuck_en = 1'b1; stuck_val = 1'b1; q_fb = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cycle(); cmd_valid = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++; $display("FAIL mis_seq j=%0d: got %b exp %b", j, got, exp_vec());
      end
      n_checks++;
      if (err_mismatch !== (j == 5)) begin
        n_fail++; $display("FAIL mis_flag j=%0d: got %b exp %b", j, err_mismatch, j == 5);
      end
      if (j < 5) cycle();
    end
    cmd_valid = 1'b1; cmd_op = 2'b00; cycle(); cmd_valid = 1'b0;
    n_checks++;
    if (err_mismatch !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mis_hold_op00: err=%b busy=%b exp 1 0", err_mismatch, busy);
    end
    cmd_valid = 1'b1; cmd_op = 2'b01; cycle(); cmd_valid = 1'b0;
    n_checks++;
    if (err_mismatch !== 1'b0) begin
      n_fail++; $display("FAIL mis_clear_on_set: got %b exp 0", err_mismatch);
    end
    for (int j = 0; j < 5; j++) begin
      cycle();
      got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++; $display("FAIL mis_tail j=%0d: got %b exp %b", j, got, exp_vec());
      end
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_illegal();
    logic q_before;
    q_before = q_exp;
    cmd_valid = 1'b1; cmd_op = 2'b11; cycle(); cmd_valid = 1'b0;
    n_checks++;
    if (err_illegal !== 1'b1 || s !== 1'b0 || r !== 1'b0 || q_exp !== q_before || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL illegal_pulse: ill=%b s=%b r=%b q_exp=%b rdy=%b exp 1 0 0 %b 1",
                         err_illegal, s, r, q_exp, cmd_ready, q_before);
    end
    cycle();
    got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
    n_checks++;
    if (got !== exp_vec() || err_illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_one_cycle: got %b exp %b", got, exp_vec());
    end
  endtask

  task automatic test_reset_mid_pulse();
    cmd_valid = 1'b1; cmd_op = 2'b01; cycle(); cmd_valid = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (s !== 1'b0 || q_exp !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pulse_async: s=%b q_exp=%b busy=%b rdy=%b exp 0 0 0 1",
                         s, q_exp, busy, cmd_ready);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
      n_checks++;
      if (got !== exp_vec()) begin
        n_fail++; $display("FAIL rst_no_check j=%0d: got %b exp %b", j, got, exp_vec());
      end
    end
  endtask

  task automatic test_params();
    int s_cnt = 0, quiet = 0, ready_at = -1;
    b_cmd_valid = 1'b1; b_cmd_op = 2'b01;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      if (b_s) s_cnt++;
      if (b_busy && !b_s && !b_r) quiet++;
      if (b_cmd_ready && ready_at < 0) ready_at = j;
      @(posedge clk); #1;
    end
    n_checks++;
    if (s_cnt != 1) begin
      n_fail++; $display("FAIL params_pulse_w: got %0d exp 1", s_cnt);
    end
    n_checks++;
    if (quiet != 4) begin
      n_fail++; $display("FAIL params_guard_plus_check: got %0d exp 4", quiet);
    end
    n_checks++;
    if (ready_at != 6) begin
      n_fail++; $display("FAIL params_ready_latency: got %0d exp 6", ready_at);
    end
    n_checks++;
    if (b_err_mismatch !== 1'b0 || b_err_illegal !== 1'b0 || b_q_exp !== 1'b1) begin
      n_fail++; $display("FAIL params_flags: mis=%b ill=%b q_exp=%b exp 0 0 1",
                         b_err_mismatch, b_err_illegal, b_q_exp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (m_j == 0) begin
        stuck_en  = ($urandom_range(0, 3) == 0);
        stuck_val = 1'($urandom_range(0, 1));
        q_fb      = stuck_en ? stuck_val : q_latch;
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      cycle();
      got = {s, r, q_exp, busy, cmd_ready, err_illegal, err_mismatch};
      n_checks++;
      if (got !== exp_vec() || (s && r)) begin
        n_fail++; $display("FAIL random i=%0d: got %b exp %b", i, got, exp_vec());
      end
    end
    cmd_valid = 1'b0; stuck_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set();
    test_back_to_back();
    test_mismatch();
    test_illegal();
    test_reset_mid_pulse();
    test_params();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
